// File: rtl/uart_tx_ctrl_if.sv
// CPU data-bus bundle for the UART transmitter: write/read strobes,
// byte address, write data with lane enables, and combinational read data.
interface uart_tx_ctrl_if;
  logic        wen;
  logic        ren;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [3:0]  byte_select;
  logic [31:0] data_out;

  modport master (output wen, ren, address, data_in, byte_select, input data_out);
  modport slave  (input wen, ren, address, data_in, byte_select, output data_out);
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable divisor,
// status/overflow register and a drained-level interrupt.
//
// state   | meaning
// S_IDLE  | line high, waiting for a FIFO entry
// S_START | start bit (low) for D clocks
// S_DATA  | 8 data bits, LSB first, D clocks each
// S_STOP  | stop bit (high) for D clocks, may chain straight into next start
module uart_tx_ctrl #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic           clkout,
  input  logic           ext_reset,
  uart_tx_ctrl_if.slave  bus,
  output logic           uart_tx,
  output logic           busy,
  output logic           irq_empty
);

  localparam int          PTR_W   = CNT_W - 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state;
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [15:0]      r_div;
  logic [15:0]      r_d_eff;
  logic [15:0]      r_timer;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_tx;
  logic             r_busy;
  logic             r_irq;

  logic [1:0]       w_sel;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_bit_end;
  logic             w_ovf_clr;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [15:0]      w_div_eff;
  logic [7:0]       w_head;
  logic [31:0]      w_status;
  logic             w_unused;

  assign w_sel       = bus.address[3:2];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_bit_end   = (r_timer == 16'd0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_div_eff   = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_push_req  = bus.wen && (w_sel == 2'd0) && bus.byte_select[0];
  assign w_ovf_clr   = bus.wen && (w_sel == 2'd1) && bus.byte_select[0] && bus.data_in[3];
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_busy_nxt  = w_pop || ((r_state != S_IDLE) && !((r_state == S_STOP) && w_bit_end));
  assign w_unused    = ^{bus.ren, bus.data_in[31:16], bus.address[1:0], bus.byte_select[3:2]};

  always_ff @(posedge clkout) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DIV_RST;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      if (w_push_req && !w_push) r_ovf <= 1'b1;
      else if (w_ovf_clr)        r_ovf <= 1'b0;
      if (bus.wen && (w_sel == 2'd2)) begin
        if (bus.byte_select[0]) r_div[7:0]  <= bus.data_in[7:0];
        if (bus.byte_select[1]) r_div[15:8] <= bus.data_in[15:8];
      end
    end
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      r_state <= S_IDLE;
      r_d_eff <= 16'd1;
      r_timer <= 16'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_irq   <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_irq  <= (w_count_nxt == '0) && !w_busy_nxt;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_d_eff <= w_div_eff;
            r_timer <= w_div_eff - 16'd1;
            r_bit   <= 3'd0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_timer <= r_d_eff - 16'd1;
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= r_d_eff - 16'd1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_d_eff <= w_div_eff;
              r_timer <= w_div_eff - 16'd1;
              r_bit   <= 3'd0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[0]              = w_full;
    w_status[1]              = w_empty;
    w_status[2]              = r_busy;
    w_status[3]              = r_ovf;
    w_status[8 +: CNT_W]     = r_count;
    bus.data_out             = '0;
    case (w_sel)
      2'd1:    bus.data_out = w_status;
      2'd2:    bus.data_out = {16'd0, r_div};
      default: bus.data_out = '0;
    endcase
  end

  assign uart_tx   = r_tx;
  assign busy      = r_busy;
  assign irq_empty = r_irq;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_ctrl;
  localparam int CLK_HZ = 27000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 8;

  logic clkout    = 1'b0;
  logic ext_reset = 1'b1;
  logic uart_tx, busy, irq_empty;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clkout(clkout), .ext_reset(ext_reset), .bus(bus),
    .uart_tx(uart_tx), .busy(busy), .irq_empty(irq_empty));

  always #5 clkout = ~clkout;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as 10 slots of D clocks each.
  logic [7:0]  m_q[$];
  bit          m_active;
  logic [7:0]  m_cur;
  int          m_pos, m_d;
  logic [15:0] m_div;
  bit          m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_pos = 0; m_d = 1; m_cur = 8'h00;
    m_div = 16'(CLK_HZ / BAUD); m_ovf = 0;
  endtask

  task automatic model_step();
    bit fin;
    fin = m_active && (m_pos == 10 * m_d - 1);
    if (m_active && !fin) m_pos++;
    else if (m_q.size() != 0) begin
      m_cur = m_q.pop_front();
      m_d = (m_div == 16'd0) ? 1 : int'(m_div);
      m_pos = 0; m_active = 1;
    end else m_active = 0;
    if (bus.wen) begin
      case (bus.address[3:2])
        2'd0: if (bus.byte_select[0]) begin
          if (m_q.size() < DEPTH) m_q.push_back(bus.data_in[7:0]);
          else m_ovf = 1;
        end
        2'd1: if (bus.byte_select[0] && bus.data_in[3]) m_ovf = 0;
        2'd2: begin
          if (bus.byte_select[0]) m_div[7:0]  = bus.data_in[7:0];
          if (bus.byte_select[1]) m_div[15:8] = bus.data_in[15:8];
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / m_d;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    int n;
    n = m_q.size();
    case (a[3:2])
      2'd1: return (32'(n) << 8) | (32'(m_ovf) << 3) | (32'(m_active) << 2)
                   | (32'(n == 0) << 1) | 32'(n == DEPTH);
      2'd2: return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clkout or negedge ext_reset);
      if (!ext_reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clkout);
      chk("cyc_tx",    32'(uart_tx),   32'(exp_tx()));
      chk("cyc_busy",  32'(busy),      32'(m_active));
      chk("cyc_irq",   32'(irq_empty), 32'((m_q.size() == 0) && !m_active));
      chk("cyc_rdata", bus.data_out,   exp_rd(bus.address));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

  // All stimulus runs at posedge+2.
  task automatic step(input int n);
    repeat (n) begin @(posedge clkout); #2; end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] bs);
    bus.wen = 1'b1; bus.address = a; bus.data_in = d; bus.byte_select = bs;
    @(posedge clkout); #2;
    bus.wen = 1'b0; bus.byte_select = 4'h0;
  endtask

  task automatic bus_read(input string nm, input logic [3:0] a, input logic [31:0] exp);
    bus.address = a; bus.ren = 1'b1;
    #1;
    chk(nm, bus.data_out, exp);
    bus.ren = 1'b0;
  endtask

  logic tx_s [0:99];
  int   bcnt;

  task automatic capture(input int n);
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      tx_s[i] = uart_tx;
      if (busy) bcnt++;
      step(1);
    end
  endtask

  logic [9:0]  lit2;
  logic [19:0] lit3;
  int          lows;

  initial begin
    bus.wen = 1'b0; bus.ren = 1'b0; bus.address = 4'h0;
    bus.data_in = 32'h0; bus.byte_select = 4'h0;
    #1 ext_reset = 1'b0;
    repeat (3) @(posedge clkout);
    #2 ext_reset = 1'b1;
    step(1);

    // Reset state
    bus_read("rst_status", 4'h4, 32'h0000_0002);
    bus_read("rst_div",    4'h8, 32'd234);
    chk("rst_tx",  32'(uart_tx),   32'd1);
    chk("rst_irq", 32'(irq_empty), 32'd1);
    chk("rst_busy", 32'(busy),     32'd0);

    // Divisor lanes, dead writes, write-only / reserved reads
    bus_write(4'h8, 32'h0000_1234, 4'b0011);
    bus_write(4'h8, 32'hFFFF_FF56, 4'b0001);
    bus_read("div_lane0", 4'h8, 32'h0000_1256);
    bus_write(4'h8, 32'hABCD_99FF, 4'b0010);
    bus_read("div_lane1", 4'h8, 32'h0000_9956);
    bus_write(4'h0, 32'h0000_0077, 4'b1110);
    bus_write(4'hC, 32'hFFFF_FFFF, 4'b1111);
    bus_read("nolane_push", 4'h4, 32'h0000_0002);
    bus_read("rd_txdata",   4'h0, 32'h0);
    bus_read("rd_reserved", 4'hC, 32'h0);

    // Single frame 0x55 at D=4
    bus_write(4'h8, 32'd4, 4'b0011);
    bus_write(4'h0, 32'h55, 4'b0001);
    chk("lat_tx_pre", 32'(uart_tx), 32'd1);
    step(1);
    capture(40);
    lit2 = 10'b1010101010;
    chk("f55_start", 32'(tx_s[0]), 32'd0);
    for (int i = 0; i < 40; i++) chk("f55_bit", 32'(tx_s[i]), 32'(lit2[i/4]));
    chk("f55_busy40", bcnt, 32'd40);
    chk("f55_busy_end", 32'(busy), 32'd0);
    chk("f55_irq_end", 32'(irq_empty), 32'd1);

    // Back-to-back frames 0xA5, 0x3C
    bus_write(4'h0, 32'hA5, 4'b0001);
    bus_write(4'h0, 32'h3C, 4'b0001);
    capture(80);
    lit3 = {10'b1001111000, 10'b1101001010};
    for (int i = 0; i < 80; i++) chk("b2b_bit", 32'(tx_s[i]), 32'(lit3[i/4]));
    chk("b2b_busy80", bcnt, 32'd80);
    chk("b2b_stop_then_start", 32'({tx_s[39], tx_s[40]}), 32'b10);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // Overflow with a stalled line
    bus_write(4'h8, 32'd1000, 4'b0011);
    for (int i = 0; i < 10; i++) bus_write(4'h0, 32'(i), 4'b0001);
    bus_read("ovf_status", 4'h4, 32'h0000_080D);
    bus_write(4'h4, 32'h8, 4'b0001);
    bus_read("ovf_clear", 4'h4, 32'h0000_0805);

    // Reset mid-DATA of the 0x00 frame
    step(1100);
    chk("mid_tx_low", 32'(uart_tx), 32'd0);
    chk("mid_busy",   32'(busy),    32'd1);
    #1 ext_reset = 1'b0;
    #1;
    chk("arst_tx",   32'(uart_tx),   32'd1);
    chk("arst_busy", 32'(busy),      32'd0);
    chk("arst_irq",  32'(irq_empty), 32'd1);
    bus_read("arst_status", 4'h4, 32'h0000_0002);
    step(2);
    ext_reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (!uart_tx || busy) lows++;
      step(1);
    end
    chk("post_rst_quiet", lows, 32'd0);
    bus_read("post_rst_div", 4'h8, 32'd234);

    // DIVISOR=0 behaves as D=1
    bus_write(4'h8, 32'd0, 4'b0011);
    bus_read("div_zero", 4'h8, 32'd0);
    bus_write(4'h0, 32'hFF, 4'b0001);
    step(1);
    capture(10);
    chk("d1_start", 32'(tx_s[0]), 32'd0);
    for (int i = 1; i < 10; i++) chk("d1_high", 32'(tx_s[i]), 32'd1);
    chk("d1_busy10", bcnt, 32'd10);
    chk("d1_busy_end", 32'(busy), 32'd0);
    chk("d1_irq_end", 32'(irq_empty), 32'd1);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Memory-mapped UART transmitter that drives the SoC `uart_tx` pin, complementing the existing receive path on `uart_rx`. It sits on the CPU data bus alongside the other peripherals and buffers bytes in a small FIFO. It serialises them as 8N1 frames at a programmable baud divisor. It provides status for polling and a level interrupt when fully drained.

Parameters:
CLK_HZ, 27000000, clkout frequency in Hz
BAUD, 115200, default baud rate; reset divisor = CLK_HZ/BAUD (integer division, 234 at defaults)
FIFO_DEPTH, 8, TX FIFO entries; power of 2, ≥2
CNT_W, 4, width of count field = log2(FIFO_DEPTH)+1

Ports:
clkout  in  1  system clock, all logic on rising edge
ext_reset  in  1  asynchronous reset, active-low
wen  in  1  bus write strobe, one cycle per access
ren  in  1  bus read strobe (no read side effects; informational only)
address  in  4  byte address; address[3:2] selects register
data_in  in  32  write data
byte_select  in  4  byte lane enables for writes
data_out  out  32  read data, combinational from address
uart_tx  out  1  serial output, idle high
busy  out  1  high while a frame is on the line
irq_empty  out  1  high when FIFO empty and not busy

Behaviour:
- Reset is asserted when ext_reset=0 and takes effect immediately, asynchronously.
  - Reset values: uart_tx=1, busy=0, irq_empty=1.
  - FIFO is emptied, overflow flag=0, divisor=CLK_HZ/BAUD, FSM=IDLE.
  - Reset mid-frame aborts the frame, and the line returns high at once.
- Register map (address[3:2]):
  - 0 TXDATA: W only. A write with byte_select[0]=1 pushes data_in[7:0]. Reads return 0.
  - 1 STATUS: R.
    - bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
    - bits[8+CNT_W-1:8] FIFO count; other bits 0.
    - Writing 1 to data_in[3] with byte_select[0]=1 clears overflow.
  - 2 DIVISOR: R/W, 16 bits, in clocks per bit. Lanes 0/1 are written per byte_select[1:0]. Upper bits read 0.
  - 3: reads 0, writes ignored.
- FIFO:
  - A push is accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Count updates on the edge that samples wen.
  - Data ordering is strictly FIFO.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty: pop the head into shift register, latch effective divisor D = max(DIVISOR,1), set bit counter=0, go to START.
  - START: uart_tx=0 for D cycles, then DATA.
  - DATA: uart_tx=shift[0], held D cycles per bit, LSB first. After 8 bits go to STOP.
  - STOP: uart_tx=1 for D cycles.
    - If FIFO is non-empty on the final STOP cycle, pop and go directly to START. There is no idle gap.
    - Otherwise go to IDLE.
- Frame length is exactly 10·D clocks.
- Timing of a frame:
  - uart_tx is registered.
  - A write sampled at edge N into an empty idle block gives a pop at edge N+1.
  - uart_tx falls at N+1, as the registered output of the START entry.
- DIVISOR writes during a frame do not affect the current frame. They take effect at the next frame start.
- busy=1 in START/DATA/STOP. irq_empty = empty & ~busy, registered.
- The bit timer is a down-counter reloaded with D-1 at each bit boundary. There is no fractional baud correction.

Test Plan:
1. Reset, then read STATUS -> 0x00000002 (empty), uart_tx=1, irq_empty=1, DIVISOR reads 234.
2. Set DIVISOR=4, write 0x55 to TXDATA -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; busy high 40 clocks; irq_empty returns 1.
3. With DIVISOR=4, write 0xA5, 0x3C back-to-back -> two frames, 80 clocks total, with no high gap between the stop bit of frame 1 and the start bit of frame 2.
4. Write 10 bytes with the line stalled (DIVISOR=1000) -> 9 accepted (1 popped, 8 in FIFO), count=8, full=1, overflow=1. Write 0x8 to STATUS -> overflow=0.
5. Assert ext_reset low mid-DATA -> uart_tx=1 in the same cycle, count=0, busy=0. After release, no residual bytes are sent.
6. Write DIVISOR=0, send 0xFF -> frame uses D=1: start bit 1 clock, then 9 high clocks, total 10 clocks.
